// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage of a 5-stage MIPS pipeline, including the IF/ID register.
// Latency: 1 cycle from fetch PC to IF/ID; a redirect leaves 1 bubble before the target word.
// Backpressure: level-sensitive Stall freezes PC, IF/ID and FetchCount; redirects override it.
//
// Ports:
//   Clk, Reset           - clock and synchronous active-high reset
//   Stall                - hold PC and IF/ID this cycle
//   Branch/BranchTarget  - taken branch from EX (highest-priority redirect)
//   Jump/JumpTarget      - j/jal/jr from ID
//   Instruction          - IF/ID instruction register
//   PCAddResult          - IF/ID fetch PC + 4
//   Valid                - IF/ID holds a real fetched instruction
//   PC                   - current fetch PC
//   FetchCount           - valid instructions latched into IF/ID since reset
//
// ROM contents arrive through ROM_IMAGE, an elaboration-time word array that the
// build flow generates from the hex image named by MEM_FILE.
module instruction_fetch_stage #(
    parameter int          MEM_DEPTH = 256,
    parameter              MEM_FILE  = "instruction_memory.mem",
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] ROM_IMAGE [MEM_DEPTH] = '{default: 32'h0000_0000}
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [31:0] Instruction,
    output logic [31:0] PCAddResult,
    output logic        Valid,
    output logic [31:0] PC,
    output logic [31:0] FetchCount
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [31:0]   pc_plus4;
    logic [31:0]   branch_pc;
    logic [31:0]   jump_pc;
    logic          in_range;
    logic [AW-1:0] rom_index;
    logic [31:0]   fetch_word;

    // 32-bit add: 0xFFFFFFFC + 4 wraps naturally to 0.
    assign pc_plus4  = PC + 32'd4;

    // Redirect targets are forced to word alignment.
    assign branch_pc = BranchTarget & ~32'h3;
    assign jump_pc   = JumpTarget   & ~32'h3;

    // Word address compared in full so addresses past the ROM fetch a NOP
    // instead of aliasing back onto low words.
    assign in_range  = {2'b00, PC[31:2]} < 32'(MEM_DEPTH);
    assign rom_index = PC[AW+1:2];

    always_comb begin
        fetch_word = 32'h0000_0000;
        if (in_range) begin
            fetch_word = ROM_IMAGE[rom_index];
        end
    end

    // Priority: Reset > Branch > Jump > Stall > normal fetch.
    // Branch beats Jump because the EX-stage instruction is older than the ID one.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC          <= RESET_PC;
            Instruction <= 32'h0000_0000;
            PCAddResult <= 32'h0000_0000;
            Valid       <= 1'b0;
            FetchCount  <= 32'h0000_0000;
        end else if (Branch) begin
            PC          <= branch_pc;
            Instruction <= 32'h0000_0000;
            PCAddResult <= 32'h0000_0000;
            Valid       <= 1'b0;
        end else if (Jump) begin
            PC          <= jump_pc;
            Instruction <= 32'h0000_0000;
            PCAddResult <= 32'h0000_0000;
            Valid       <= 1'b0;
        end else if (!Stall) begin
            PC          <= pc_plus4;
            Instruction <= fetch_word;
            PCAddResult <= pc_plus4;
            Valid       <= 1'b1;
            FetchCount  <= FetchCount + 32'd1;
        end
    end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction fetch stage of the 5-stage MIPS pipeline, including the IF/ID pipeline register. It holds the program counter and reads a word-addressed instruction ROM. It presents `Instruction` and `PCAddResult` to the decode stage on the following cycle. It accepts stall from the hazard unit and PC redirects from branch resolution (EX) and jump decode (ID), squashing the wrong-path instruction with a NOP.

## Interface
- `MEM_DEPTH`, default 256: number of 32-bit instruction words in the ROM.
- `MEM_FILE`, default "instruction_memory.mem": hex image loaded into the ROM at elaboration.
- `RESET_PC`, default 32'h00000000: PC value loaded on reset.
- `Clk`, input, 1: single clock; all state updates on rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `Stall`, input, 1: hold PC and IF/ID contents this cycle.
- `Branch`, input, 1: taken branch resolved in EX; redirect to `BranchTarget`.
- `BranchTarget`, input, 32: byte address of branch destination.
- `Jump`, input, 1: j/jal/jr decoded in ID; redirect to `JumpTarget`.
- `JumpTarget`, input, 32: byte address of jump destination.
- `Instruction`, output, 32: IF/ID instruction register, feeds decode stage.
- `PCAddResult`, output, 32: IF/ID register holding fetch PC + 4.
- `Valid`, output, 1: IF/ID holds a real fetched instruction (0 for reset/flush bubble).
- `PC`, output, 32: current fetch PC.
- `FetchCount`, output, 32: number of valid instructions latched into IF/ID since reset.

## Operation
- ROM index = `PC[log2(MEM_DEPTH)+1:2]`. If `PC[31:2]` is greater than or equal to `MEM_DEPTH`, the fetched word is 32'h00000000 (NOP). The ROM read is combinational.
- Targets are word-aligned before use: `{target[31:2],2'b00}`.
- Per-edge priority, highest first:
  1. **Reset:** PC = `RESET_PC`; `Instruction`, `PCAddResult`, `FetchCount` = 0; `Valid` = 0.
  2. **Branch:** PC = `BranchTarget`; IF/ID flushed (`Instruction` = 0, `PCAddResult` = 0, `Valid` = 0). `Branch` wins over a simultaneous `Jump`, because the EX instruction is older.
  3. **Jump:** PC = `JumpTarget`; IF/ID flushed as above.
  4. **Stall:** PC, IF/ID, and `FetchCount` all held.
  5. **Normal:** IF/ID takes `{ROM[PC], PC+4, Valid=1}`; PC = PC+4; `FetchCount` += 1.
- Redirect overrides `Stall` for both PC and IF/ID.
- Arithmetic widths:
  - PC+4 is 32-bit, wrapping at 32'hFFFFFFFC to 0.
  - `FetchCount` wraps modulo 2^32.
- `FetchCount` increments only on normal-case edges.
- Reset asserted mid-stall or mid-redirect still takes effect on that edge; the first fetch afterward is at `RESET_PC`.

## Timing
- All outputs change only on the rising edge of `Clk`.
- All outputs reach their reset values on the first edge with `Reset`=1.
- Fetch-to-IF/ID latency: 1 cycle. The first edge after `Reset` deasserts latches `ROM[RESET_PC>>2]` with `PCAddResult` = `RESET_PC`+4.
- Redirect penalty:
  - 1 bubble cycle (`Valid`=0) in IF/ID.
  - The target instruction appears in IF/ID on the second edge after `Branch`/`Jump` is sampled high.
- `Stall` is level-sensitive. N consecutive stall cycles freeze outputs for exactly N edges. There is no skid and no lost or duplicated instruction.
- `Branch`/`Jump` are sampled each edge and are single-cycle pulses. Holding one high re-redirects every edge, re-flushing IF/ID each time.

## Test plan
ROM image: word0 = 20080005, word1 = 20090003, word2 = 01095020, word3 = 01095822, word16 = 71096002; `RESET_PC` = 0.

- **Reset then run:** `Reset` high 2 edges, then low for 3 edges.
  - During reset: `Instruction` = 0, `Valid` = 0, `PC` = 0.
  - Then `Instruction` = 20080005 / 20090003 / 01095020.
  - `PCAddResult` = 4 / 8 / C.
  - `FetchCount` = 3, `PC` = 0xC.
- **Stall:** after word1 is in IF/ID, assert `Stall` for 2 edges.
  - `Instruction` stays 20090003; `PC` stays 8; `FetchCount` unchanged.
  - Release: next edge gives 01095020.
- **Branch redirect:** `Branch`=1, `BranchTarget`=0x40 for one edge while `PC`=8.
  - That edge: `Instruction` = 0, `Valid` = 0, `PC` = 0x40.
  - Next edge: `Instruction` = 71096002, `PCAddResult` = 0x44.
- **Simultaneous events:**
  - `Branch`=1 (target 0x40), `Jump`=1 (target 0x8), and `Stall`=1 in the same cycle: `PC` = 0x40, IF/ID flushed.
  - `Jump` alone with target 0x6: `PC` = 0x4.
- **Out-of-range and reset mid-run:**
  - With `MEM_DEPTH`=256, jump to 0x400: `Instruction` = 0, `Valid` = 1 on the next edge.
  - Assert `Reset` during a stall: all outputs return to reset values on that edge, and `FetchCount` = 0.
